// File: rtl/sysid_boot_checker.sv
// sysid_boot_checker: reads the system ID peripheral (word 0 = ID, word 1 = build
// timestamp) over Avalon-MM, compares both words against build-time constants and
// reports pass / mismatch / timeout to the boot supervisor.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start (or the automatic post-reset check)
// ID_REQ  | read of word 0 presented, waiting for waitrequest low
// ID_WAIT | read of word 0 accepted, waiting for readdatavalid
// TS_REQ  | read of word 1 presented, waiting for waitrequest low
// TS_WAIT | read of word 1 accepted, waiting for readdatavalid
// CHECK   | compare captured words against the expected values
// FIN     | raise done/valid, drop busy, return to IDLE
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1456594139,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 2,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);

  typedef enum logic [2:0] {
    IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, CHECK, FIN
  } state_t;

  // Timeout fires on the edge where the per-read cycle count reaches TIMEOUT_CYCLES.
  localparam logic [15:0] TLAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RMAX  = 4'(MAX_RETRIES);

  state_t      state;
  logic [15:0] tcnt;
  logic [3:0]  retry;
  logic        auto_pend;
  // A response arriving on the acceptance edge is parked here and consumed in WAIT.
  logic        early_vld;
  logic [31:0] early_data;

  logic        in_read;
  logic        in_wait;
  logic        got;
  logic        tmo;
  logic [31:0] got_data;

  assign in_read  = (state == ID_REQ) || (state == ID_WAIT) ||
                    (state == TS_REQ) || (state == TS_WAIT);
  assign in_wait  = (state == ID_WAIT) || (state == TS_WAIT);
  assign got      = in_wait && (avm_readdatavalid || early_vld);
  assign got_data = early_vld ? early_data : avm_readdata;
  assign tmo      = in_read && (tcnt == TLAST);

  // Sequencer with registered status and bus outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      tcnt        <= '0;
      retry       <= '0;
      auto_pend   <= AUTO_START;
      early_vld   <= 1'b0;
      early_data  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      valid       <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
      avm_address <= 1'b0;
      avm_read    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (in_read) tcnt <= tcnt + 16'd1;

      case (state)
        IDLE: begin
          if (start || auto_pend) begin
            auto_pend   <= 1'b0;
            busy        <= 1'b1;
            valid       <= 1'b0;
            pass        <= 1'b0;
            id_mismatch <= 1'b0;
            ts_mismatch <= 1'b0;
            timeout_err <= 1'b0;
            retry       <= '0;
            tcnt        <= '0;
            early_vld   <= 1'b0;
            avm_read    <= 1'b1;
            avm_address <= 1'b0;
            state       <= ID_REQ;
          end
        end
        ID_REQ, TS_REQ: begin
          if (!avm_waitrequest) begin
            avm_read   <= 1'b0;
            early_vld  <= avm_readdatavalid;
            early_data <= avm_readdata;
            state      <= (state == ID_REQ) ? ID_WAIT : TS_WAIT;
          end
        end
        ID_WAIT: begin
          if (got) begin
            id_value    <= got_data;
            early_vld   <= 1'b0;
            tcnt        <= '0;
            avm_read    <= 1'b1;
            avm_address <= 1'b1;
            state       <= TS_REQ;
          end
        end
        TS_WAIT: begin
          if (got) begin
            ts_value  <= got_data;
            early_vld <= 1'b0;
            state     <= CHECK;
          end
        end
        CHECK: begin
          id_mismatch <= (id_value != EXPECTED_ID);
          ts_mismatch <= (ts_value != EXPECTED_TS);
          pass        <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
          state       <= FIN;
        end
        FIN: begin
          done  <= 1'b1;
          valid <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A capture on the timeout edge still counts; otherwise retry from word 0.
      if (tmo && !got) begin
        avm_read  <= 1'b0;
        early_vld <= 1'b0;
        tcnt      <= '0;
        if (retry < RMAX) begin
          retry       <= retry + 4'd1;
          avm_read    <= 1'b1;
          avm_address <= 1'b0;
          state       <= ID_REQ;
        end else begin
          timeout_err <= 1'b1;
          state       <= FIN;
        end
      end
    end
  end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Bench for sysid_boot_checker: a scripted Avalon slave answers reads according to a
// per-request plan (stall cycles, response latency, 0 = never answers); a reference
// model derives sequence length and result from that plan with plain arithmetic.
module tb_sysid_boot_checker;

  localparam int          T      = 8;
  localparam int          MR     = 2;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1456594139;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done, valid, pass, id_mismatch, ts_mismatch, timeout_err;
  logic [31:0] id_value, ts_value;
  logic        avm_address, avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  sysid_boot_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
    .TIMEOUT_CYCLES(T), .MAX_RETRIES(MR), .AUTO_START(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .busy(busy), .done(done), .valid(valid), .pass(pass),
    .id_mismatch(id_mismatch), .ts_mismatch(ts_mismatch), .timeout_err(timeout_err),
    .id_value(id_value), .ts_value(ts_value),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // request plan and reference model results
  int          p_stall[8];
  int          p_lat[8];
  bit          exp_addr[8];
  logic [31:0] id_word, ts_word;
  int          n_req;
  int          e_n;
  bit          e_tmo, e_pass, e_idm, e_tsm;

  function automatic int cost(input int i);
    return (p_lat[i] == 0) ? 100000 : p_stall[i] + 1 + p_lat[i];
  endfunction

  task automatic model();
    int pos, el, att, c;
    bit ok, fin_ok;
    pos = 0; el = 0; att = 0; e_tmo = 0; fin_ok = 0;
    while (!fin_ok && !e_tmo) begin
      ok = 1;
      for (int ph = 0; ph < 2 && ok; ph++) begin
        exp_addr[pos] = ph[0];
        c = cost(pos);
        pos++;
        if (c < T) el += c;
        else begin el += T; ok = 0; end
      end
      if (ok) fin_ok = 1;
      else if (att < MR) att++;
      else e_tmo = 1;
    end
    n_req  = pos;
    e_n    = e_tmo ? el + 1 : el + 2;
    e_idm  = !e_tmo && (id_word != EXP_ID);
    e_tsm  = !e_tmo && (ts_word != EXP_TS);
    e_pass = !e_tmo && !e_idm && !e_tsm;
  endtask

  // scripted slave
  int          sidx = 0;
  bit          in_req = 0;
  int          stall_left = 0;
  int          cur_lat = 0;
  int          lat_cnt = 0;
  logic [31:0] pend_data = '0;
  logic        req_addr = 1'b0;

  initial begin
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(negedge clock);
      avm_readdatavalid = 1'b0;
      avm_waitrequest   = 1'b0;
      avm_readdata      = $urandom;
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = pend_data;
        end
      end
      if (reset) in_req = 0;
      else begin
        if (in_req) chk("read_held", avm_read, 1);
        if (avm_read) begin
          if (!in_req) begin
            in_req = 1;
            if (sidx < n_req) begin
              chk("req_addr", avm_address, exp_addr[sidx]);
              stall_left = p_stall[sidx];
              cur_lat    = p_lat[sidx];
            end else begin
              stall_left = 0;
              cur_lat    = 1;
            end
            req_addr = avm_address;
            sidx++;
          end else begin
            chk("addr_stable", avm_address, req_addr);
          end
          if (stall_left > 0) begin
            avm_waitrequest = 1'b1;
            stall_left--;
          end else begin
            in_req = 0;
            if (cur_lat > 0) begin
              lat_cnt   = cur_lat;
              pend_data = req_addr ? ts_word : id_word;
            end
          end
        end
      end
    end
  end

  task automatic set_plan(input int st, input int lt, input logic [31:0] idw, input logic [31:0] tsw);
    for (int i = 0; i < 8; i++) begin p_stall[i] = st; p_lat[i] = lt; end
    id_word = idw; ts_word = tsw;
    model();
    sidx = 0;
  endtask

  task automatic rand_plan();
    for (int i = 0; i < 8; i++) begin
      p_stall[i] = $urandom_range(0, 3);
      p_lat[i]   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
    end
    case ($urandom_range(0, 2))
      0: id_word = EXP_ID;
      1: id_word = EXP_ID ^ (32'd1 << $urandom_range(0, 31));
      default: id_word = $urandom;
    endcase
    case ($urandom_range(0, 2))
      0: ts_word = EXP_TS;
      1: ts_word = EXP_TS ^ (32'd1 << $urandom_range(0, 31));
      default: ts_word = $urandom;
    endcase
    model();
    sidx = 0;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ctl"}, {busy, done, valid, pass, id_mismatch, ts_mismatch,
                        timeout_err, avm_address, avm_read}, 0);
    chk({tag, "_idv"}, id_value, 0);
    chk({tag, "_tsv"}, ts_value, 0);
  endtask

  task automatic wait_busy(output int t0);
    int k;
    k = 0;
    while (!busy && k < 20) begin @(negedge clock); k++; end
    chk("busy_rise", busy, 1);
    chk("valid_clr", valid, 0);
    t0 = cyc;
  endtask

  // start_at: -2 leave start alone, -1 no pulse, else pulse start at that cycle offset
  task automatic wait_done(input int t0, input int start_at);
    int k;
    k = 0;
    while (!done && k < 300) begin
      @(negedge clock);
      k++;
      if (start_at >= -1) start = (k == start_at);
      if (!done) chk("busy_during", busy, 1);
    end
    chk("done_seen", done, 1);
    chk("seq_len", cyc - t0, e_n);
    chk("valid", valid, 1);
    chk("busy_end", busy, 0);
    chk("timeout_err", timeout_err, e_tmo);
    chk("pass", pass, e_pass);
    chk("id_mismatch", id_mismatch, e_idm);
    chk("ts_mismatch", ts_mismatch, e_tsm);
    if (!e_tmo) begin
      chk("id_value", id_value, id_word);
      chk("ts_value", ts_value, ts_word);
    end
    @(negedge clock);
    chk("done_pulse", done, 0);
    if (start_at != -2) chk("read_idle", avm_read, 0);
  endtask

  task automatic idle_check(input int n);
    repeat (n) begin
      @(negedge clock);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_read", avm_read, 0);
    end
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    reset = 1'b1;
    start = 1'b0;

    // automatic check after reset, zero stall, latency 1
    set_plan(0, 1, EXP_ID, EXP_TS);
    repeat (3) @(negedge clock);
    check_reset_outs("reset");
    reset = 1'b0;
    wait_busy(t0);
    wait_done(t0, -1);
    chk("min_len", e_n, 7 - 1);
    idle_check(3);

    // word 0 mismatch
    set_plan(0, 1, 32'h0000_0001, EXP_TS);
    pulse_start();
    wait_busy(t0);
    wait_done(t0, -1);
    idle_check(2);

    // 5 stall cycles on every read: 10 cycles longer than the no-stall case
    set_plan(5, 1, EXP_ID, EXP_TS);
    pulse_start();
    wait_busy(t0);
    wait_done(t0, -1);
    chk("stall_len", e_n, 16);
    idle_check(2);

    // slave never answers: three attempts of T cycles each
    set_plan(0, 0, EXP_ID, EXP_TS);
    pulse_start();
    wait_busy(t0);
    wait_done(t0, 3);
    chk("tmo_len", e_n, 3 * T + 1);
    chk("tmo_reqs", sidx, 3);
    idle_check(3);

    // mid-sequence start ignored, reset during TS_WAIT, late response ignored
    set_plan(0, 1, EXP_ID, 32'hDEAD_BEEF);
    p_lat[1] = 4;
    model();
    pulse_start();
    wait_busy(t0);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset_outs("mid_reset");
    set_plan(0, 1, EXP_ID, EXP_TS);
    p_stall[0] = 2;
    model();
    reset = 1'b0;
    wait_busy(t0);
    repeat (2) @(negedge clock);
    chk("stale_idv", id_value, 0);
    chk("stale_tsv", ts_value, 0);
    wait_done(t0, -1);
    idle_check(3);

    // start held high retriggers after each completion
    set_plan(0, 1, EXP_ID, EXP_TS);
    @(negedge clock);
    start = 1'b1;
    wait_busy(t0);
    wait_done(t0, -2);
    chk("held_retrig", busy, 1);
    start = 1'b0;
    t0 = cyc;
    chk("held_valid_clr", valid, 0);
    wait_done(t0, -1);
    idle_check(2);

    // randomized plans with occasional ignored start pulses
    for (int it = 0; it < 40; it++) begin
      rand_plan();
      pulse_start();
      wait_busy(t0);
      wait_done(t0, ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(1, e_n - 1));
      idle_check($urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
